// File: rtl/iagu_dotacc_mc_if.sv
// Control and IOB read-port bundle of the DOTACC input address generator.
// The master side is the sequencer/controller and the slave side is the generator.
interface iagu_dotacc_mc_if #(
    parameter int ADDR_W      = 16,
    parameter int BANK_ADDR_W = 12,
    parameter int PIECE_W     = 8
);
    logic                   i_start;
    logic [1:0]             i_mode;
    logic [ADDR_W-1:0]      i_base_a;
    logic [ADDR_W-1:0]      i_base_b;
    logic [ADDR_W-1:0]      i_stride;
    logic [PIECE_W-1:0]     i_in_pieces;
    logic [PIECE_W-1:0]     i_out_pieces;
    logic                   i_stall;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_ren0;
    logic [BANK_ADDR_W-1:0] o_raddr0;
    logic                   o_ren1;
    logic [BANK_ADDR_W-1:0] o_raddr1;
    logic                   o_acc_clear;
    logic                   o_acc_out;

    modport master (
        output i_start, i_mode, i_base_a, i_base_b, i_stride,
               i_in_pieces, i_out_pieces, i_stall,
        input  o_busy, o_done, o_ren0, o_raddr0, o_ren1, o_raddr1,
               o_acc_clear, o_acc_out
    );

    modport slave (
        input  i_start, i_mode, i_base_a, i_base_b, i_stride,
               i_in_pieces, i_out_pieces, i_stall,
        output o_busy, o_done, o_ren0, o_raddr0, o_ren1, o_raddr1,
               o_acc_clear, o_acc_out
    );
endinterface

// File: rtl/iagu_dotacc_mc.sv
// DOTACC input address generator: walks the (output piece x input piece) grid
// for operands A and B and issues reads on the two IOB bank ports, with stall
// back-pressure, accumulator clear/out strobes and busy/done status.
module iagu_dotacc_mc #(
    parameter int ADDR_W      = 16,
    parameter int BANK_ADDR_W = 12,
    parameter int PIECE_W     = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    iagu_dotacc_mc_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} state_t;

    localparam logic [1:0] MODE_IL   = 2'b00;
    localparam logic [1:0] MODE_DUAL = 2'b01;
    localparam logic [1:0] MODE_RSV  = 2'b11;

    state_t               state;
    logic                 busy_q;
    logic                 done_q;
    logic                 acc_out_q;

    // Configuration latched at start acceptance
    logic [1:0]           cfg_mode;
    logic [ADDR_W-1:0]    cfg_stride;
    logic [PIECE_W-1:0]   cfg_in;
    logic [PIECE_W-1:0]   cfg_out;

    // Walk state: ptr is the current read address, row is base + o
    logic [ADDR_W-1:0]    ptr_a;
    logic [ADDR_W-1:0]    row_a;
    logic [ADDR_W-1:0]    ptr_b;
    logic [ADDR_W-1:0]    row_b;
    logic [PIECE_W-1:0]   i_cnt;
    logic [PIECE_W-1:0]   o_cnt;
    logic [BANK_ADDR_W-1:0] hold0;
    logic [BANK_ADDR_W-1:0] hold1;

    logic                 start_ok;
    logic                 reject;
    logic                 running;
    logic                 issue;
    logic                 step_a;
    logic                 step_b;
    logic                 step;
    logic                 last_i;
    logic                 last_o;
    logic [ADDR_W-1:0]    ptr_a_nxt;
    logic [ADDR_W-1:0]    row_a_nxt;
    logic [ADDR_W-1:0]    ptr_b_nxt;
    logic [ADDR_W-1:0]    row_b_nxt;
    logic                 rd_bank;
    logic [BANK_ADDR_W-1:0] rd_low;
    logic                 ren0;
    logic                 ren1;
    logic [BANK_ADDR_W-1:0] raddr0;
    logic [BANK_ADDR_W-1:0] raddr1;

    assign start_ok = (state == IDLE) && bus.i_start;
    assign reject   = (bus.i_in_pieces == '0) || (bus.i_out_pieces == '0) ||
                      (bus.i_mode == MODE_RSV);
    assign running  = (state == RUN_A) || (state == RUN_B);
    assign issue    = running && !bus.i_stall;

    // A advances on every A read; B advances on its own read (interleaved)
    // or alongside A (dual-buffer). The grid step completes on the last
    // read belonging to the (o,i) step.
    assign step_a = issue && (state == RUN_A);
    assign step_b = issue && ((state == RUN_B) ||
                              ((state == RUN_A) && (cfg_mode == MODE_DUAL)));
    assign step   = issue && ((state == RUN_B) || (cfg_mode != MODE_IL));

    assign last_i = (i_cnt == cfg_in - PIECE_W'(1));
    assign last_o = (o_cnt == cfg_out - PIECE_W'(1));

    // Incremental address walk; at an output-piece boundary restart at base + o + 1
    always_comb begin
        ptr_a_nxt = ptr_a + cfg_stride;
        row_a_nxt = row_a;
        ptr_b_nxt = ptr_b + cfg_stride;
        row_b_nxt = row_b;
        if (last_i) begin
            ptr_a_nxt = row_a + ADDR_W'(1);
            row_a_nxt = row_a + ADDR_W'(1);
            ptr_b_nxt = row_b + ADDR_W'(1);
            row_b_nxt = row_b + ADDR_W'(1);
        end
    end

    // Port routing: dual-buffer pins A/B to ports 0/1, otherwise the bank bit selects
    always_comb begin
        rd_bank = (state == RUN_B) ? ptr_b[BANK_ADDR_W] : ptr_a[BANK_ADDR_W];
        rd_low  = (state == RUN_B) ? ptr_b[BANK_ADDR_W-1:0] : ptr_a[BANK_ADDR_W-1:0];
        ren0    = 1'b0;
        ren1    = 1'b0;
        raddr0  = hold0;
        raddr1  = hold1;
        if (issue) begin
            if (cfg_mode == MODE_DUAL) begin
                ren0   = 1'b1;
                raddr0 = ptr_a[BANK_ADDR_W-1:0];
                ren1   = 1'b1;
                raddr1 = ptr_b[BANK_ADDR_W-1:0];
            end else if (rd_bank) begin
                ren1   = 1'b1;
                raddr1 = rd_low;
            end else begin
                ren0   = 1'b1;
                raddr0 = rd_low;
            end
        end
    end

    // Configuration latch, grid counters, pointers and held port addresses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_mode   <= '0;
            cfg_stride <= '0;
            cfg_in     <= '0;
            cfg_out    <= '0;
            ptr_a      <= '0;
            row_a      <= '0;
            ptr_b      <= '0;
            row_b      <= '0;
            i_cnt      <= '0;
            o_cnt      <= '0;
            hold0      <= '0;
            hold1      <= '0;
        end else begin
            hold0 <= raddr0;
            hold1 <= raddr1;
            if (start_ok) begin
                cfg_mode   <= bus.i_mode;
                cfg_stride <= bus.i_stride;
                cfg_in     <= bus.i_in_pieces;
                cfg_out    <= bus.i_out_pieces;
                ptr_a      <= bus.i_base_a;
                row_a      <= bus.i_base_a;
                ptr_b      <= bus.i_base_b;
                row_b      <= bus.i_base_b;
                i_cnt      <= '0;
                o_cnt      <= '0;
            end else begin
                if (step_a) begin
                    ptr_a <= ptr_a_nxt;
                    row_a <= row_a_nxt;
                end
                if (step_b) begin
                    ptr_b <= ptr_b_nxt;
                    row_b <= row_b_nxt;
                end
                if (step) begin
                    if (last_i) begin
                        i_cnt <= '0;
                        o_cnt <= o_cnt + PIECE_W'(1);
                    end else begin
                        i_cnt <= i_cnt + PIECE_W'(1);
                    end
                end
            end
        end
    end

    // Sequencing FSM with registered busy/done/acc_out status
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_out_q <= 1'b0;
        end else begin
            acc_out_q <= step && last_i;
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_start) begin
                        busy_q <= 1'b1;
                        if (reject) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN_A;
                        end
                    end
                end
                RUN_A: begin
                    if (issue) begin
                        if (step && last_i && last_o) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (cfg_mode == MODE_IL) begin
                            state <= RUN_B;
                        end
                    end
                end
                RUN_B: begin
                    if (issue) begin
                        if (last_i && last_o) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN_A;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_acc_out   = acc_out_q;
    assign bus.o_acc_clear = (state == RUN_A) && (i_cnt == '0);
    assign bus.o_ren0      = ren0;
    assign bus.o_raddr0    = raddr0;
    assign bus.o_ren1      = ren1;
    assign bus.o_raddr1    = raddr1;

endmodule

// File: tb/tb_iagu_dotacc_mc.sv
// Bench for iagu_dotacc_mc: directed table, reset/abort sequence and
// randomized jobs against a grid-level reference of the read stream.
module tb_iagu_dotacc_mc;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    iagu_dotacc_mc_if #(.ADDR_W(16), .BANK_ADDR_W(12), .PIECE_W(8)) bus ();

    iagu_dotacc_mc #(.ADDR_W(16), .BANK_ADDR_W(12), .PIECE_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One issuing cycle of the expected read stream
    typedef struct packed {
        logic        ren0;
        logic [11:0] a0;
        logic        ren1;
        logic [11:0] a1;
        logic        clear;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ba;
        logic [15:0] bb;
        logic [15:0] st;
        logic [7:0]  inp;
        logic [7:0]  outp;
        int          stall_mode;
        bit          mid_start;
        int          exp_reads;
        int          exp_busy;
        logic [12:0] exp_first;
        logic [12:0] exp_last;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t bank_beat(input logic [15:0] addr, input bit clr, input bit lst);
        beat_t b;
        b = '0;
        if (addr[12]) begin
            b.ren1 = 1'b1;
            b.a1   = addr[11:0];
        end else begin
            b.ren0 = 1'b1;
            b.a0   = addr[11:0];
        end
        b.clear = clr;
        b.last  = lst;
        return b;
    endfunction

    // Runs one job; checks every cycle against the reference stream and
    // returns port-read count, busy-cycle count and first/last {port,addr}.
    task automatic run_job(input logic [1:0] mode, input logic [15:0] ba, input logic [15:0] bb,
                           input logic [15:0] st, input logic [7:0] inp, input logic [7:0] outp,
                           input int stall_mode, input bit mid_start,
                           output int nreads, output int busy_cyc,
                           output logic [12:0] first_rd, output logic [12:0] last_rd);
        beat_t beats[$];
        beat_t b;
        int    idx;
        int    cyc;
        int    stall_left;
        bit    stall;
        bit    prev_last;
        bit    got_first;
        beats = {};
        if (mode != 2'b11) begin
            for (int o = 0; o < int'(outp); o++) begin
                for (int i = 0; i < int'(inp); i++) begin
                    logic [15:0] a;
                    logic [15:0] bbq;
                    a   = 16'(ba + o + i * st);
                    bbq = 16'(bb + o + i * st);
                    if (mode == 2'b00) begin
                        beats.push_back(bank_beat(a, i == 0, 1'b0));
                        beats.push_back(bank_beat(bbq, 1'b0, i == int'(inp) - 1));
                    end else if (mode == 2'b01) begin
                        b = '0;
                        b.ren0 = 1'b1; b.a0 = a[11:0];
                        b.ren1 = 1'b1; b.a1 = bbq[11:0];
                        b.clear = (i == 0);
                        b.last  = (i == int'(inp) - 1);
                        beats.push_back(b);
                    end else begin
                        beats.push_back(bank_beat(a, i == 0, i == int'(inp) - 1));
                    end
                end
            end
        end
        nreads = 0; busy_cyc = 0; first_rd = '0; last_rd = '0;
        got_first = 1'b0; prev_last = 1'b0; idx = 0; cyc = 0; stall_left = 3;

        bus.i_mode = mode; bus.i_base_a = ba; bus.i_base_b = bb; bus.i_stride = st;
        bus.i_in_pieces = inp; bus.i_out_pieces = outp; bus.i_stall = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;

        while (idx < beats.size() && cyc < 4000) begin
            case (stall_mode)
                1: stall = ($urandom_range(0, 3) == 0);
                2: stall = (idx == 2) && (stall_left > 0);
                default: stall = 1'b0;
            endcase
            if (stall_mode == 2 && stall) stall_left--;
            bus.i_stall = stall;
            if (mid_start) begin
                bus.i_start     = ($urandom_range(0, 2) == 0);
                bus.i_mode      = 2'($urandom_range(0, 3));
                bus.i_base_a    = 16'($urandom);
                bus.i_stride    = 16'($urandom);
                bus.i_in_pieces = 8'($urandom_range(0, 3));
            end
            #1;
            b = beats[idx];
            check("ren0", 32'(bus.o_ren0), stall ? 32'd0 : 32'(b.ren0));
            check("ren1", 32'(bus.o_ren1), stall ? 32'd0 : 32'(b.ren1));
            if (!stall && b.ren0) check("raddr0", 32'(bus.o_raddr0), 32'(b.a0));
            if (!stall && b.ren1) check("raddr1", 32'(bus.o_raddr1), 32'(b.a1));
            check("acc_clear", 32'(bus.o_acc_clear), 32'(b.clear));
            check("acc_out", 32'(bus.o_acc_out), 32'(prev_last));
            check("done_run", 32'(bus.o_done), 32'd0);
            busy_cyc += int'(bus.o_busy);
            if (bus.o_ren0 || bus.o_ren1) begin
                nreads += int'(bus.o_ren0) + int'(bus.o_ren1);
                if (!got_first) first_rd = bus.o_ren0 ? {1'b0, bus.o_raddr0} : {1'b1, bus.o_raddr1};
                got_first = 1'b1;
                last_rd = bus.o_ren1 ? {1'b1, bus.o_raddr1} : {1'b0, bus.o_raddr0};
            end
            prev_last = stall ? 1'b0 : b.last;
            if (!stall) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        if (idx < beats.size()) check("timeout_reads", 32'(idx), 32'(beats.size()));

        // DONE cycle: a stall here must not matter
        bus.i_start = 1'b0;
        bus.i_stall = 1'($urandom_range(0, 1));
        #1;
        check("done", 32'(bus.o_done), 32'd1);
        check("busy_done", 32'(bus.o_busy), 32'd1);
        check("ren_done", {30'd0, bus.o_ren1, bus.o_ren0}, 32'd0);
        check("clear_done", 32'(bus.o_acc_clear), 32'd0);
        check("acc_out_done", 32'(bus.o_acc_out), 32'(prev_last));
        busy_cyc += int'(bus.o_busy);
        @(posedge clk); #1;
        bus.i_stall = 1'b0;
        #1;
        check("done_clear", 32'(bus.o_done), 32'd0);
        check("busy_clear", 32'(bus.o_busy), 32'd0);
        check("acc_out_idle", 32'(bus.o_acc_out), 32'd0);
        check("ren_idle", {30'd0, bus.o_ren1, bus.o_ren0}, 32'd0);
    endtask

    initial begin
        int          nr;
        int          bc;
        logic [12:0] fr;
        logic [12:0] lr;
        n_tests = 0;
        n_fail  = 0;

        //            mode   ba        bb        st     in    out   stl mid  reads busy first     last
        vecs[0] = '{2'b00, 16'h0010, 16'h1020, 16'd2, 8'd3, 8'd2, 0, 1'b0, 12, 13, 13'h0010, 13'h1025};
        vecs[1] = '{2'b01, 16'h0010, 16'h1020, 16'd2, 8'd3, 8'd2, 0, 1'b0, 12, 7,  13'h0010, 13'h1025};
        vecs[2] = '{2'b10, 16'h0FFE, 16'h0000, 16'd1, 8'd4, 8'd1, 0, 1'b0, 4,  5,  13'h0FFE, 13'h1001};
        vecs[3] = '{2'b10, 16'h0FFE, 16'h0000, 16'd1, 8'd4, 8'd1, 2, 1'b0, 4,  8,  13'h0FFE, 13'h1001};
        vecs[4] = '{2'b10, 16'hFFFF, 16'h0000, 16'd1, 8'd2, 8'd1, 0, 1'b0, 2,  3,  13'h1FFF, 13'h0000};
        vecs[5] = '{2'b00, 16'h0010, 16'h1020, 16'd2, 8'd0, 8'd2, 0, 1'b0, 0,  1,  13'h0000, 13'h0000};
        vecs[6] = '{2'b11, 16'h0010, 16'h1020, 16'd2, 8'd3, 8'd2, 0, 1'b0, 0,  1,  13'h0000, 13'h0000};
        vecs[7] = '{2'b00, 16'h0010, 16'h1020, 16'd2, 8'd3, 8'd2, 0, 1'b1, 12, 13, 13'h0010, 13'h1025};

        bus.i_start = 1'b0; bus.i_mode = 2'b00; bus.i_base_a = '0; bus.i_base_b = '0;
        bus.i_stride = '0; bus.i_in_pieces = '0; bus.i_out_pieces = '0; bus.i_stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_ren", {30'd0, bus.o_ren1, bus.o_ren0}, 32'd0);
        check("rst_raddr", {8'd0, bus.o_raddr1, bus.o_raddr0}, 32'd0);
        check("rst_acc", {30'd0, bus.o_acc_clear, bus.o_acc_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            run_job(vecs[v].mode, vecs[v].ba, vecs[v].bb, vecs[v].st, vecs[v].inp, vecs[v].outp,
                    vecs[v].stall_mode, vecs[v].mid_start, nr, bc, fr, lr);
            check($sformatf("vec%0d_reads", v), 32'(nr), 32'(vecs[v].exp_reads));
            check($sformatf("vec%0d_busy", v), 32'(bc), 32'(vecs[v].exp_busy));
            if (vecs[v].exp_reads > 0) begin
                check($sformatf("vec%0d_first", v), 32'(fr), 32'(vecs[v].exp_first));
                check($sformatf("vec%0d_last", v), 32'(lr), 32'(vecs[v].exp_last));
            end
        end

        // Reset in the middle of a 12-read interleaved job, at read 4
        bus.i_mode = 2'b00; bus.i_base_a = 16'h0010; bus.i_base_b = 16'h1020;
        bus.i_stride = 16'd2; bus.i_in_pieces = 8'd3; bus.i_out_pieces = 8'd2;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1;
        check("abort_read4_ren1", 32'(bus.o_ren1), 32'd1);
        check("abort_read4_addr", 32'(bus.o_raddr1), 32'h022);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_done", 32'(bus.o_done), 32'd0);
        check("abort_ren", {30'd0, bus.o_ren1, bus.o_ren0}, 32'd0);
        check("abort_raddr", {8'd0, bus.o_raddr1, bus.o_raddr0}, 32'd0);
        check("abort_acc", {30'd0, bus.o_acc_clear, bus.o_acc_out}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", {30'd0, bus.o_done, bus.o_busy}, 32'd0);
        end
        run_job(2'b00, 16'h0010, 16'h1020, 16'd2, 8'd3, 8'd2, 0, 1'b0, nr, bc, fr, lr);
        check("rerun_reads", 32'(nr), 32'd12);
        check("rerun_busy", 32'(bc), 32'd13);
        check("rerun_first", 32'(fr), 32'h0010);

        // Randomized jobs with random stalls and stray start pulses
        for (int j = 0; j < 25; j++) begin
            logic [1:0] m;
            logic [7:0] ip;
            logic [7:0] op;
            int         exp_n;
            int         sel;
            sel = $urandom_range(0, 7);
            m   = (sel == 7) ? 2'b11 : 2'(sel % 3);
            ip  = 8'($urandom_range(0, 5));
            op  = 8'($urandom_range(0, 4));
            run_job(m, 16'($urandom), 16'($urandom), 16'($urandom), ip, op,
                    1, 1'($urandom_range(0, 1)), nr, bc, fr, lr);
            if (m == 2'b11 || ip == 0 || op == 0) exp_n = 0;
            else if (m == 2'b10) exp_n = int'(ip) * int'(op);
            else exp_n = 2 * int'(ip) * int'(op);
            check($sformatf("rand%0d_reads", j), 32'(nr), 32'(exp_n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
